// File: rtl/mux_rram_pkg.sv
// Shared constants, state type and one-hot helper for the 4-input RRAM routing mux.
package mux_rram_pkg;

  localparam int MUX_SIZE  = 4;
  localparam int BLWL_SIZE = MUX_SIZE + 1;
  // Output-side bit-line/word-line index: bl[OUT_LINE] clears, wl[OUT_LINE] sets.
  localparam int OUT_LINE  = MUX_SIZE;

  typedef logic [0:MUX_SIZE-1] rram_state_t;

  function automatic logic is_onehot(input logic [0:BLWL_SIZE-1] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < BLWL_SIZE; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

endpackage

// File: rtl/rram_cell.sv
// One RRAM element: ON/OFF state bit; simultaneous set and clear leave it unchanged.
module rram_cell (
  input  logic prog_clock,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic on
);

  always_ff @(posedge prog_clock) begin
    if (rst)              on <= 1'b0;
    else if (set && !clr) on <= 1'b1;
    else if (clr && !set) on <= 1'b0;
  end

endmodule

// File: rtl/mux_1level_size4.sv
// 4-input one-level 4T1R RRAM routing mux: BL/WL programming decode plus priority output select.
// Optional MUX_RRAM_PROG_GUARD_EN: apply a programming cycle only when bl and wl are each one-hot.
module mux_1level_size4
  import mux_rram_pkg::*;
#(
  parameter int MUX_SIZE  = mux_rram_pkg::MUX_SIZE,
  parameter int BLWL_SIZE = mux_rram_pkg::BLWL_SIZE
) (
  input  logic                 prog_clock,
  input  logic                 rst,
  input  logic                 prog_EN,
  input  logic                 prog_ENb,
  input  logic [0:MUX_SIZE-1]  in,
  output logic                 out,
  input  logic [0:BLWL_SIZE-1] bl,
  input  logic [0:BLWL_SIZE-1] wl
);

  logic                prog_act;
  logic                prog_ok;
  logic [0:MUX_SIZE-1] set;
  logic [0:MUX_SIZE-1] clr;
  logic [0:MUX_SIZE-1] on;

  // Only the 10 encoding of the differential enable counts as programming.
  assign prog_act = prog_EN & ~prog_ENb;

`ifdef MUX_RRAM_PROG_GUARD_EN
  assign prog_ok = prog_act & is_onehot(bl) & is_onehot(wl);
`else
  assign prog_ok = prog_act;
`endif

  genvar g;
  generate
    for (g = 0; g < MUX_SIZE; g++) begin : g_cell
      assign set[g] = prog_ok & bl[g] & wl[OUT_LINE];
      assign clr[g] = prog_ok & bl[OUT_LINE] & wl[g];

      rram_cell u_cell (
        .prog_clock (prog_clock),
        .rst        (rst),
        .set        (set[g]),
        .clr        (clr[g]),
        .on         (on[g])
      );
    end
  endgenerate

  // Scan high-to-low so the lowest ON index wins; datapath isolated while programming.
  always_comb begin
    out = 1'b0;
    if (!prog_act) begin
      for (int i = MUX_SIZE - 1; i >= 0; i--) begin
        if (on[i]) out = in[i];
      end
    end
  end

endmodule

// File: tb/tb_mux_1level_size4.sv
// Directed self-checking bench for mux_1level_size4 (honours MUX_RRAM_PROG_GUARD_EN).
module tb_mux_1level_size4;

  logic       prog_clock = 1'b0;
  logic       rst;
  logic       prog_EN;
  logic       prog_ENb;
  logic [0:3] in;
  logic       out;
  logic [0:4] bl;
  logic [0:4] wl;

  int checks = 0;
  int errors = 0;

  always #5 prog_clock = ~prog_clock;

  mux_1level_size4 dut (
    .prog_clock (prog_clock),
    .rst        (rst),
    .prog_EN    (prog_EN),
    .prog_ENb   (prog_ENb),
    .in         (in),
    .out        (out),
    .bl         (bl),
    .wl         (wl)
  );

  // Element state as a 4-bit value, element 0 in the leftmost digit.
  logic [3:0] on_obs;
  assign on_obs = dut.on;

  task automatic tick();
    @(posedge prog_clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic exp);
    #1;
    checks++;
    assert (out === exp)
      else begin
        errors++;
        $error("FAIL %s: out=%b expected %b", tag, out, exp);
      end
  endtask

  task automatic chk_on(input string tag, input logic [3:0] exp);
    #1;
    checks++;
    assert (on_obs === exp)
      else begin
        errors++;
        $error("FAIL %s: on=%b expected %b", tag, on_obs, exp);
      end
  endtask

  task automatic prog(input logic [4:0] b, input logic [4:0] w);
    prog_EN = 1'b1; prog_ENb = 1'b0; bl = b; wl = w;
    tick();
  endtask

  task automatic run_mode();
    prog_EN = 1'b0; prog_ENb = 1'b1; bl = '0; wl = '0;
  endtask

  initial begin
    rst = 1'b1; prog_EN = 1'b0; prog_ENb = 1'b1;
    in = 4'b1111; bl = '0; wl = '0;
    tick();
    rst = 1'b0;
    chk_out("reset_out", 1'b0);
    chk_on("reset_on", 4'b0000);

    // Set element 0; output isolated while programming
    prog_EN = 1'b1; prog_ENb = 1'b0; bl = 5'b10000; wl = 5'b00001;
    chk_out("isolate_first", 1'b0);
    tick();
    run_mode();
    in = 4'b1000; chk_out("el0_in1", 1'b1);
    chk_on("el0_on", 4'b1000);
    in = 4'b0111; chk_out("el0_in0", 1'b0);

    // Clear element 0, set element 2
    prog(5'b00001, 5'b10000);
    prog(5'b00100, 5'b00001);
    run_mode();
    chk_on("el2_on", 4'b0010);
    in = 4'b0010; chk_out("el2_in1", 1'b1);
    in = 4'b1101; chk_out("el2_in0", 1'b0);

    // Rotating bit-line with wl[4]; bl[4]/wl[4] pair must do nothing
    prog(5'b10000, 5'b00001);
    prog(5'b01000, 5'b00001);
    prog(5'b00100, 5'b00001);
    prog(5'b00010, 5'b00001);
    chk_on("rot_all_on", 4'b1111);
    prog(5'b00001, 5'b00001);
    chk_on("rot_out_pair", 4'b1111);
    run_mode();
    in = 4'b0100; chk_out("prio_el0_0", 1'b0);
    in = 4'b1000; chk_out("prio_el0_1", 1'b1);

    // Isolation and same-cycle conflicts
    prog_EN = 1'b1; prog_ENb = 1'b0; in = 4'b1111;
    chk_out("isolate_1111", 1'b0);
    prog(5'b10001, 5'b10001);
    chk_on("conflict_on_el", 4'b1111);
    prog(5'b00001, 5'b01000);
    chk_on("clear_el1", 4'b1011);
    prog(5'b01001, 5'b01001);
    chk_on("conflict_off_el", 4'b1011);

    // Enable 11 is not programming: state held, output live
    prog_EN = 1'b1; prog_ENb = 1'b1; bl = 5'b01000; wl = 5'b00001;
    in = 4'b1000; chk_out("en11_out", 1'b1);
    tick();
    chk_on("en11_hold", 4'b1011);

    // Reset beats programming in the same cycle
    rst = 1'b1; prog_EN = 1'b1; prog_ENb = 1'b0; bl = 5'b10000; wl = 5'b00001;
    tick();
    rst = 1'b0;
    chk_on("rst_priority", 4'b0000);

    // Multi-hot bit-lines: guarded build ignores the whole cycle
    prog(5'b11000, 5'b00001);
    run_mode();
    in = 4'b1000;
`ifdef MUX_RRAM_PROG_GUARD_EN
    chk_on("multihot_on", 4'b0000);
    chk_out("multihot_out", 1'b0);
`else
    chk_on("multihot_on", 4'b1100);
    chk_out("multihot_out", 1'b1);
`endif

    // Programming proceeds normally after reset
    prog(5'b00010, 5'b00001);
    run_mode();
    in = 4'b0001;
`ifdef MUX_RRAM_PROG_GUARD_EN
    chk_on("post_rst_on", 4'b0001);
    chk_out("post_rst_out", 1'b1);
`else
    chk_on("post_rst_on", 4'b1101);
    chk_out("post_rst_out", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
